// File: rtl/sabr_mul_pkg.sv
// Shared types and width helpers for the SABR pipelined fixed-point multiplier.
// Optional rounding in the top level is enabled by defining SABR_MUL_ROUND_EN.
package sabr_mul_pkg;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } mul_mode_e;

    function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
        return a_w + b_w;
    endfunction

    function automatic int unsigned dout_width(input int unsigned a_w, input int unsigned b_w,
                                               input int unsigned frac_shift);
        return prod_width(a_w, b_w) - frac_shift;
    endfunction

    localparam int unsigned DEF_P_W   = prod_width(43, 36);
    localparam int unsigned DEF_TAG_W = 8;

    // Payload at the default geometry; the top level passes a re-sized twin to each stage.
    typedef struct packed {
        logic [DEF_P_W-1:0]   product;
        logic [DEF_TAG_W-1:0] tag;
    } stage_payload_t;

endpackage

// File: rtl/sabr_mul_stage.sv
// One valid/ready register slice of the multiplier pipeline.
// Loads whenever the top level says the slot is empty or being drained downstream.
module sabr_mul_stage
    import sabr_mul_pkg::*;
#(
    parameter type payload_t = stage_payload_t
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     up_valid,
    input  payload_t up_data,
    output logic     valid,
    output payload_t data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/sabr_mul_pipe.sv
// Pipelined signed/unsigned fixed-point multiplier with valid/ready flow control.
// Define SABR_MUL_ROUND_EN to add round-half-up before the fractional right shift.
module sabr_mul_pipe
    import sabr_mul_pkg::*;
#(
    parameter int unsigned A_W        = 43,
    parameter int unsigned B_W        = 36,
    parameter int unsigned STAGES     = 1,
    parameter int unsigned FRAC_SHIFT = 0,
    parameter int unsigned TAG_W      = 8,
    localparam int unsigned P_W       = prod_width(A_W, B_W),
    localparam int unsigned DOUT_W    = dout_width(A_W, B_W, FRAC_SHIFT),
    localparam int unsigned OCC_W     = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_W-1:0]    din0,
    input  logic [B_W-1:0]    din1,
    input  logic              is_signed,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] dout,
    output logic [TAG_W-1:0]  tag_out,
    output logic [OCC_W-1:0]  occupancy
);

    typedef struct packed {
        logic [DOUT_W-1:0] product;
        logic [TAG_W-1:0]  tag;
    } payload_t;

    mul_mode_e          mode;
    logic signed [P_W:0] a_ext;
    logic signed [P_W:0] b_ext;
    logic signed [P_W:0] prod;
    logic signed [P_W:0] rounded;
    payload_t           stage_in;
    payload_t           stage_data [STAGES];
    logic [STAGES-1:0]  stage_valid;
    logic [STAGES-1:0]  stage_load;
    logic               accept;
    logic               deliver;

    // One guard bit lets both modes share a single signed multiply and arithmetic shift.
    assign mode  = mul_mode_e'(is_signed);
    assign a_ext = signed'({{(P_W + 1 - A_W){(mode == SIGNED) && din0[A_W-1]}}, din0});
    assign b_ext = signed'({{(P_W + 1 - B_W){(mode == SIGNED) && din1[B_W-1]}}, din1});
    assign prod  = a_ext * b_ext;

`ifdef SABR_MUL_ROUND_EN
    if (FRAC_SHIFT > 0) begin : g_round
        localparam logic signed [P_W:0] HALF = (P_W + 1)'(1) << (FRAC_SHIFT - 1);
        assign rounded = prod + HALF;
    end else begin : g_no_round
        assign rounded = prod;
    end
`else
    assign rounded = prod;
`endif

    assign stage_in.product = DOUT_W'(rounded >>> FRAC_SHIFT);
    assign stage_in.tag     = tag_in;

    // A stage may load when it is empty or the stage after it loads this cycle.
    always_comb begin
        stage_load             = '0;
        stage_load[STAGES-1]   = out_ready || !stage_valid[STAGES-1];
        for (int unsigned i = 0; i < STAGES - 1; i++) begin
            stage_load[STAGES-2-i] = stage_load[STAGES-1-i] || !stage_valid[STAGES-2-i];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            sabr_mul_stage #(.payload_t(payload_t)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .load     (stage_load[k]),
                .up_valid (in_valid),
                .up_data  (stage_in),
                .valid    (stage_valid[k]),
                .data     (stage_data[k])
            );
        end else begin : g_body
            sabr_mul_stage #(.payload_t(payload_t)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .load     (stage_load[k]),
                .up_valid (stage_valid[k-1]),
                .up_data  (stage_data[k-1]),
                .valid    (stage_valid[k]),
                .data     (stage_data[k])
            );
        end
    end

    assign in_ready  = stage_load[0] && !reset;
    assign out_valid = stage_valid[STAGES-1];
    assign dout      = stage_data[STAGES-1].product;
    assign tag_out   = stage_data[STAGES-1].tag;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else if (accept && !deliver) begin
            occupancy <= occupancy + 1'b1;
        end else if (deliver && !accept) begin
            occupancy <= occupancy - 1'b1;
        end
    end

endmodule

// File: tb/tb_sabr_mul_pipe.sv
// Self-checking bench for sabr_mul_pipe: vector table, corner-case sequences, random streaming.
// Expected rounded results follow SABR_MUL_ROUND_EN when the bench is built with it.
module tb_sabr_mul_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // u_a: defaults (STAGES=1); u_b: STAGES=3; u_c: STAGES=2, FRAC_SHIFT=4
    logic        a_in_valid, a_in_ready, a_is_signed, a_out_valid, a_out_ready;
    logic [42:0] a_din0;
    logic [35:0] a_din1;
    logic [7:0]  a_tag_in, a_tag_out;
    logic [78:0] a_dout;
    logic [0:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_is_signed, b_out_valid, b_out_ready;
    logic [42:0] b_din0;
    logic [35:0] b_din1;
    logic [7:0]  b_tag_in, b_tag_out;
    logic [78:0] b_dout;
    logic [1:0]  b_occ;

    logic        c_in_valid, c_in_ready, c_is_signed, c_out_valid, c_out_ready;
    logic [42:0] c_din0;
    logic [35:0] c_din1;
    logic [7:0]  c_tag_in, c_tag_out;
    logic [74:0] c_dout;
    logic [1:0]  c_occ;

    sabr_mul_pipe u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .din0(a_din0), .din1(a_din1), .is_signed(a_is_signed), .tag_in(a_tag_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout),
        .tag_out(a_tag_out), .occupancy(a_occ)
    );

    sabr_mul_pipe #(.STAGES(3)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .din0(b_din0), .din1(b_din1), .is_signed(b_is_signed), .tag_in(b_tag_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
        .tag_out(b_tag_out), .occupancy(b_occ)
    );

    sabr_mul_pipe #(.STAGES(2), .FRAC_SHIFT(4)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .din0(c_din0), .din1(c_din1), .is_signed(c_is_signed), .tag_in(c_tag_in),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .dout(c_dout),
        .tag_out(c_tag_out), .occupancy(c_occ)
    );

    typedef struct {
        int          dut;
        logic [42:0] a;
        logic [35:0] b;
        logic        s;
        logic [7:0]  tag;
        logic [78:0] exp;
    } vec_t;

    typedef struct {
        logic [78:0] p;
        logic [7:0]  tag;
    } exp_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Exact product from the operand rules, using wide signed arithmetic.
    function automatic logic [78:0] ref_prod(input logic [42:0] a, input logic [35:0] b,
                                             input logic s);
        logic signed [127:0] xa, xb, p;
        xa = s ? {{85{a[42]}}, a} : {85'b0, a};
        xb = s ? {{92{b[35]}}, b} : {92'b0, b};
        p  = xa * xb;
        return p[78:0];
    endfunction

    function automatic int stages_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 2;
    endfunction

    task automatic drive(input int d, input logic v, input logic [42:0] a, input logic [35:0] b,
                         input logic s, input logic [7:0] t);
        case (d)
            0: begin a_in_valid = v; a_din0 = a; a_din1 = b; a_is_signed = s; a_tag_in = t; end
            1: begin b_in_valid = v; b_din0 = a; b_din1 = b; b_is_signed = s; b_tag_in = t; end
            default: begin c_in_valid = v; c_din0 = a; c_din1 = b; c_is_signed = s; c_tag_in = t; end
        endcase
    endtask

    task automatic sample(input int d, output logic ov, output logic [78:0] got,
                          output logic [7:0] t);
        case (d)
            0: begin ov = a_out_valid; got = a_dout; t = a_tag_out; end
            1: begin ov = b_out_valid; got = b_dout; t = b_tag_out; end
            default: begin ov = c_out_valid; got = {4'b0, c_dout}; t = c_tag_out; end
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        logic        ov;
        logic [78:0] got, exp_cmp;
        logic [7:0]  gtag;
        int          lat;
        @(negedge clk);
        drive(v.dut, 1'b1, v.a, v.b, v.s, v.tag);
        @(posedge clk);
        @(negedge clk);
        drive(v.dut, 1'b0, '0, '0, 1'b0, '0);
        #1;
        lat = 1;
        sample(v.dut, ov, got, gtag);
        while (!ov && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
            sample(v.dut, ov, got, gtag);
        end
        exp_cmp = v.exp;
        if (v.dut == 2) exp_cmp[78:75] = '0;
        check("vec_out_valid", 128'(ov), 128'(1));
        check("vec_latency", 128'(lat), 128'(stages_of(v.dut)));
        check("vec_dout", 128'(got), 128'(exp_cmp));
        check("vec_tag", 128'(gtag), 128'(v.tag));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [78:0] umax;
        logic [7:0]  got_tags[$];
        exp_t        q[$];
        exp_t        e;
        int          idx, seen, sent, cyc;
        logic        rdy;

        umax = '1;
        umax = umax - (79'd1 << 43) - (79'd1 << 36) + 79'd2;

        vecs.push_back('{0, 43'h7FF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b0, 8'h01, umax});
        vecs.push_back('{0, 43'h0, 36'hF_FFFF_FFFF, 1'b0, 8'h02, 79'h0});
        vecs.push_back('{0, 43'h400_0000_0000, 36'h8_0000_0000, 1'b1, 8'h03, 79'h2000_0000_0000_0000_0000});
        vecs.push_back('{0, 43'h400_0000_0000, 36'h1, 1'b1, 8'h04, 79'h7FFF_FFFF_FC00_0000_0000});
        vecs.push_back('{0, 43'h400_0000_0000, 36'h1, 1'b0, 8'h05, 79'h400_0000_0000});
        vecs.push_back('{0, 43'h7FF_FFFF_FFFF, 36'h1, 1'b1, 8'h06, 79'h7FFF_FFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{1, 43'h7FF_FFFF_FFFD, 36'h5, 1'b1, 8'hA5, 79'h7FFF_FFFF_FFFF_FFFF_FFF1});
`ifdef SABR_MUL_ROUND_EN
        vecs.push_back('{2, 43'd6, 36'd4, 1'b0, 8'h21, 79'd2});
        vecs.push_back('{2, 43'h7FF_FFFF_FFFA, 36'd4, 1'b1, 8'h22, 79'h7FFF_FFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2, 43'd8, 36'd1, 1'b0, 8'h23, 79'd1});
        vecs.push_back('{2, 43'd40, 36'd1, 1'b0, 8'h24, 79'd3});
        vecs.push_back('{2, 43'h7FF_FFFF_FFD8, 36'd1, 1'b1, 8'h25, 79'h7FFF_FFFF_FFFF_FFFF_FFFE});
`else
        vecs.push_back('{2, 43'd6, 36'd4, 1'b0, 8'h21, 79'd1});
        vecs.push_back('{2, 43'h7FF_FFFF_FFFA, 36'd4, 1'b1, 8'h22, 79'h7FFF_FFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{2, 43'd8, 36'd1, 1'b0, 8'h23, 79'd0});
        vecs.push_back('{2, 43'd40, 36'd1, 1'b0, 8'h24, 79'd2});
        vecs.push_back('{2, 43'h7FF_FFFF_FFD8, 36'd1, 1'b1, 8'h25, 79'h7FFF_FFFF_FFFF_FFFF_FFFD});
`endif

        reset = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, '0, '0, 1'b0, '0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        c_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        check("rst_a_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_a_occ", 128'(a_occ), 128'(0));
        check("rst_a_in_ready", 128'(a_in_ready), 128'(1));
        check("rst_a_dout", 128'(a_dout), 128'(0));
        check("rst_b_tag_out", 128'(b_tag_out), 128'(0));
        check("rst_b_occ", 128'(b_occ), 128'(0));
        check("rst_c_dout", 128'(c_dout), 128'(0));
        check("rst_c_in_ready", 128'(c_in_ready), 128'(1));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: five offers into a 3-deep pipe with the consumer stalled.
        @(negedge clk);
        b_out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1, idx < 5, 43'(idx + 1), 36'd7, 1'b0, 8'h10 + 8'(idx));
            #1 rdy = b_in_ready;
            @(posedge clk);
            if (b_in_valid && rdy) idx++;
        end
        @(negedge clk);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        #1;
        check("bp_accepted", 128'(idx), 128'(3));
        check("bp_in_ready", 128'(b_in_ready), 128'(0));
        check("bp_occ", 128'(b_occ), 128'(3));
        check("bp_out_valid_held", 128'(b_out_valid), 128'(1));
        check("bp_tag_held", 128'(b_tag_out), 128'(8'h10));
        check("bp_dout_held", 128'(b_dout), 128'(7));

        // Full pipe, consumer ready: accept and deliver in the same cycle.
        @(negedge clk);
        drive(1, 1'b1, 43'd4, 36'd7, 1'b0, 8'h13);
        b_out_ready = 1'b1;
        #1;
        check("full_in_ready", 128'(b_in_ready), 128'(1));
        got_tags.delete();
        if (b_out_valid && b_out_ready) got_tags.push_back(b_tag_out);
        @(negedge clk);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        #1;
        check("full_occ_steady", 128'(b_occ), 128'(3));
        for (int i = 0; i < 8; i++) begin
            if (b_out_valid && b_out_ready) got_tags.push_back(b_tag_out);
            @(negedge clk);
            #1;
        end
        check("drain_count", 128'(got_tags.size()), 128'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < got_tags.size()) check("drain_order", 128'(got_tags[k]), 128'(8'h10 + 8'(k)));
        end
        check("drain_occ", 128'(b_occ), 128'(0));

        // Reset with two beats in flight.
        b_out_ready = 1'b0;
        @(negedge clk);
        drive(1, 1'b1, 43'd9, 36'd9, 1'b0, 8'hE0);
        @(negedge clk);
        drive(1, 1'b1, 43'd3, 36'd3, 1'b0, 8'hE1);
        @(negedge clk);
        drive(1, 1'b0, '0, '0, 1'b0, '0);
        #1;
        check("rst_pre_occ", 128'(b_occ), 128'(2));
        reset = 1'b1;
        #1;
        check("in_ready_in_reset", 128'(b_in_ready), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(b_out_valid), 128'(0));
        check("rst_mid_occ", 128'(b_occ), 128'(0));
        check("rst_mid_in_ready", 128'(b_in_ready), 128'(1));
        check("rst_mid_tag", 128'(b_tag_out), 128'(0));
        b_out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (b_out_valid) seen++;
            @(negedge clk);
            #1;
        end
        check("rst_no_stale", 128'(seen), 128'(0));

        // Random streaming with mixed modes and 50% consumer stalls.
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            b_in_valid  = (sent < 1000) && ($urandom_range(0, 99) < 70);
            b_din0      = 43'({$urandom(), $urandom()});
            b_din1      = 36'({$urandom(), $urandom()});
            if ($urandom_range(0, 15) == 0) b_din0 = '1;
            if ($urandom_range(0, 15) == 0) b_din1 = '1;
            b_is_signed = 1'($urandom_range(0, 1));
            b_tag_in    = 8'(sent);
            b_out_ready = 1'($urandom_range(0, 1));
            #1;
            check("stream_occ", 128'(b_occ), 128'(q.size()));
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL stream_spurious: got tag %0h, expected no output", b_tag_out);
                end else begin
                    e = q.pop_front();
                    check("stream_dout", 128'(b_dout), 128'(e.p));
                    check("stream_tag", 128'(b_tag_out), 128'(e.tag));
                end
            end
            if (b_in_valid && b_in_ready) begin
                q.push_back('{ref_prod(b_din0, b_din1, b_is_signed), b_tag_in});
                sent++;
            end
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        check("stream_sent", 128'(sent), 128'(1000));
        check("stream_drained", 128'(q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
